// File: rtl/icache_param.sv
// ---------------------------------------------------------------------------
// icache_param
//
// Parametrised read-only instruction cache sitting between the fetch stage
// and the memory controller. Set-associative (1 or 2 ways) with one LRU bit
// per set, multi-word blocks, and a sequential word-by-word fill FSM.
//
// Parameters:
//   IIDX_W  set index width, sets = 2**IIDX_W
//   IBLK_W  block offset width, words per block = 2**IBLK_W (0 = 1 word)
//   IWAYS   associativity, 1 or 2
//
// Ports:
//   CLK        in   rising-edge clock
//   nRST       in   asynchronous active-low reset
//   imemREN    in   fetch read request
//   imemaddr   in   fetch byte address (bits [1:0] ignored)
//   ihit       out  request hits this cycle, imemload valid
//   imemload   out  instruction word (0 when ihit=0)
//   flush      in   invalidate every frame (aborts an in-progress fill)
//   iREN       out  memory read request, high for the whole fill
//   iaddr      out  memory word address during fill (0 otherwise)
//   iwait      in   memory not ready; word accepted when iREN & !iwait
//   iload      in   memory read data, valid when iwait=0
//   hit_count  out  (ICACHE_STATS_EN only) IDLE cycles with ihit=1
//   miss_count out  (ICACHE_STATS_EN only) IDLE->FILL transitions
//
// Optional feature macro: ICACHE_STATS_EN adds the two 32-bit wrapping
// statistics counters. They are cleared by nRST only, never by flush.
//
// Handshake: the fill side is a request/accept scheme. iREN and iaddr are
// held stable until a cycle with iREN=1 and iwait=0; that cycle transfers
// iload into the cache and advances to the next word of the block.
// ---------------------------------------------------------------------------
module icache_param #(
    parameter int IIDX_W = 4,
    parameter int IBLK_W = 1,
    parameter int IWAYS  = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int SETS  = 1 << IIDX_W;
    localparam int WPB   = 1 << IBLK_W;
    localparam int TAG_W = 30 - IIDX_W - IBLK_W;
    // Word-counter / offset width; kept at least 1 bit so a 1-word block
    // still has a legal (always-zero) counter.
    localparam int OFF_W = (IBLK_W > 0) ? IBLK_W : 1;
    localparam logic [OFF_W-1:0] LAST_WCNT = OFF_W'(WPB - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Address split of the incoming request
    // -----------------------------------------------------------------------
    logic [TAG_W-1:0]  req_tag;
    logic [IIDX_W-1:0] req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              unused_byte_off;

    assign req_tag         = imemaddr[31 -: TAG_W];
    assign req_idx         = imemaddr[IBLK_W+2 +: IIDX_W];
    assign unused_byte_off = ^imemaddr[1:0];

    generate
        if (IBLK_W > 0) begin : g_blkoff
            assign req_off = imemaddr[2 +: OFF_W];
        end else begin : g_no_blkoff
            assign req_off = '0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Storage. Valid and LRU bits are reset; tag and data arrays are not,
    // since a frame is only ever read while its valid bit is set.
    // -----------------------------------------------------------------------
    logic [SETS-1:0]  valid_q [IWAYS];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [IWAYS][SETS];
    logic [31:0]      data_q  [IWAYS][SETS][WPB];

    // Miss FSM state and the block latched at miss time
    state_t            state_q, state_d;
    logic [OFF_W-1:0]  wcnt_q, wcnt_d;
    logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
    logic [IIDX_W-1:0] lat_idx_q, lat_idx_d;
    logic              lat_way_q, lat_way_d;

    // -----------------------------------------------------------------------
    // Tag compare
    // -----------------------------------------------------------------------
    logic [IWAYS-1:0] way_hit;
    logic             hit_any;
    logic             hit_way;

    always_comb begin
        way_hit = '0;
        hit_way = 1'b0;
        for (int w = 0; w < IWAYS; w++) begin
            way_hit[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
            // At most one way can match, so the last match is the match.
            if (way_hit[w]) begin
                hit_way = 1'(w);
            end
        end
    end

    assign hit_any = |way_hit;

    // -----------------------------------------------------------------------
    // Victim selection: first invalid way (way 0 preferred), else LRU.
    // -----------------------------------------------------------------------
    logic victim;

    generate
        if (IWAYS == 2) begin : g_victim_2way
            always_comb begin
                victim = lru_q[req_idx];
                if (!valid_q[0][req_idx]) begin
                    victim = 1'b0;
                end else if (!valid_q[1][req_idx]) begin
                    victim = 1'b1;
                end
            end
        end else begin : g_victim_1way
            assign victim = 1'b0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Event decode. flush masks every other event on the same edge.
    // -----------------------------------------------------------------------
    logic lookup_hit;
    logic miss_start;
    logic word_acc;
    logic last_word;

    assign lookup_hit = (state_q == IDLE) && imemREN && hit_any && !flush;
    assign miss_start = (state_q == IDLE) && imemREN && !hit_any && !flush;
    assign word_acc   = (state_q == FILL) && !iwait && !flush;
    assign last_word  = word_acc && (wcnt_q == LAST_WCNT);

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic [31:0] fill_addr;

    // The block base is zero in the offset field, so OR-ing in the word
    // counter produces the current word address.
    assign fill_addr = {lat_tag_q, lat_idx_q, {(IBLK_W+2){1'b0}}}
                     | (32'(wcnt_q) << 2);

    assign ihit     = lookup_hit;
    assign imemload = lookup_hit ? data_q[hit_way][req_idx][req_off] : 32'h0;
    assign iREN     = (state_q == FILL);
    assign iaddr    = (state_q == FILL) ? fill_addr : 32'h0;

    // -----------------------------------------------------------------------
    // Miss FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        lat_tag_d = lat_tag_q;
        lat_idx_d = lat_idx_q;
        lat_way_d = lat_way_q;

        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    lat_tag_d = req_tag;
                    lat_idx_d = req_idx;
                    lat_way_d = victim;
                    wcnt_d    = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                // Changes of imemREN/imemaddr are ignored here: the latched
                // block is always completed unless flush aborts it.
                if (flush) begin
                    state_d = IDLE;
                end else if (word_acc) begin
                    if (wcnt_q == LAST_WCNT) begin
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + OFF_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control state, valid and LRU bits
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            lat_tag_q <= '0;
            lat_idx_q <= '0;
            lat_way_q <= 1'b0;
            lru_q     <= '0;
            for (int w = 0; w < IWAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            lat_tag_q <= lat_tag_d;
            lat_idx_q <= lat_idx_d;
            lat_way_q <= lat_way_d;

            if (flush) begin
                for (int w = 0; w < IWAYS; w++) begin
                    valid_q[w] <= '0;
                end
            end else if (last_word) begin
                valid_q[lat_way_q][lat_idx_q] <= 1'b1;
            end

            // LRU names the way NOT just used. A hit and a fill completion
            // cannot coincide: hits only happen in IDLE.
            if (IWAYS == 2) begin
                if (lookup_hit) begin
                    lru_q[req_idx] <= ~hit_way;
                end else if (last_word) begin
                    lru_q[lat_idx_q] <= ~lat_way_q;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Tag and data arrays (no reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (word_acc) begin
            data_q[lat_way_q][lat_idx_q][wcnt_q] <= iload;
        end
        if (last_word) begin
            tag_q[lat_way_q][lat_idx_q] <= lat_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics counters, wrapping modulo 2**32
    // -----------------------------------------------------------------------
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_param.sv
// ---------------------------------------------------------------------------
// tb_icache_param
//
// Self-checking bench for icache_param at default parameters
// (16 sets, 2 words per block, 2 ways). Expected instruction words are
// pushed to exp_q when a fetch is issued and popped when ihit appears.
// Miss latencies and hit/miss outcomes come from a small reference model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_icache_param;

    localparam int IIDX_W = 4;
    localparam int IBLK_W = 1;
    localparam int IWAYS  = 2;
    localparam int WPB    = 1 << IBLK_W;
    localparam int TAG_W  = 30 - IIDX_W - IBLK_W;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 CLK = ~CLK;

    icache_param #(
        .IIDX_W(IIDX_W),
        .IBLK_W(IBLK_W),
        .IWAYS (IWAYS)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .flush     (flush),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    // -----------------------------------------------------------------------
    // Bench state
    // -----------------------------------------------------------------------
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    // Memory responder state
    int          stall_n   = 0;
    int          stall_cnt = 0;
    int          fill_idx  = 0;
    logic [31:0] fill_base = 32'h0;
    logic [31:0] acc_log[$];
    bit          ren_seen  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return {wa[15:0], ~wa[15:0]} ^ 32'h3C5A_96E1 ^ {wa[31:16], 16'h0};
    endfunction

    // -----------------------------------------------------------------------
    // Driver: one clock cycle. Drives request inputs at the falling edge,
    // plays the memory side (stalls stall_n cycles before every word) and
    // checks that iaddr walks the expected block word by word.
    // -----------------------------------------------------------------------
    task automatic cyc(input logic ren, input logic [31:0] addr, input logic fl);
        logic [31:0] want;
        @(negedge CLK);
        imemREN  = ren;
        imemaddr = addr;
        flush    = fl;
        iwait    = 1'b0;
        iload    = 32'hDEAD_BEEF;
        if (iREN === 1'b1) begin
            ren_seen = 1'b1;
            want = fill_base + 32'(4 * fill_idx);
            n_vec++;
            if (iaddr !== want) begin
                n_fail++;
                $display("FAIL fill_iaddr: iaddr=%h expected %h", iaddr, want);
            end
            if (stall_cnt < stall_n) begin
                iwait = 1'b1;
                stall_cnt++;
            end else begin
                iload     = mem_word(iaddr);
                stall_cnt = 0;
                acc_log.push_back(iaddr);
                fill_idx  = (fill_idx + 1) % WPB;
            end
        end
        #1;
    endtask

    // Driver: hold a request until ihit (bounded). lat = cycles without hit,
    // or -1 on timeout. Pushes the expected word onto the scoreboard.
    task automatic fetch(input logic [31:0] addr, output int lat, output logic [31:0] word);
        bit got;
        exp_q.push_back(mem_word(addr));
        fill_base = addr & ~32'((4 << IBLK_W) - 1);
        fill_idx  = 0;
        stall_cnt = 0;
        ren_seen  = 1'b0;
        acc_log.delete();
        got  = 1'b0;
        lat  = 0;
        word = 'x;
        for (int c = 0; c < 80 && !got; c++) begin
            cyc(1'b1, addr, 1'b0);
            if (ihit === 1'b1) begin
                got  = 1'b1;
                word = imemload;
            end else begin
                lat++;
            end
        end
        if (!got) begin
            lat = -1;
        end
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        flush    = 1'b0;
        iwait    = 1'b0;
        iload    = 32'h0;
        nRST     = 1'b1;
        #1 nRST  = 1'b0;
        #1;
        n_vec += 4;
        if (ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit: got %b want 0", ihit); end
        if (iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iREN: got %b want 0", iREN); end
        if (iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
        if (imemload !== 32'h0) begin n_fail++; $display("FAIL reset_imemload: got %h want 0", imemload); end
        imemREN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        n_vec += 2;
        if (iREN !== 1'b0) begin n_fail++; $display("FAIL post_reset_iREN: got %b want 0", iREN); end
        if (ihit !== 1'b0) begin n_fail++; $display("FAIL post_reset_ihit: got %b want 0", ihit); end
    endtask

    task automatic test_cold_miss();
        int lat;
        logic [31:0] w, e;
        stall_n = 0;
        fetch(32'h0000_0040, lat, w);
        e = exp_q.pop_front();
        n_vec += 3;
        if (w !== e) begin n_fail++; $display("FAIL cold_data: got %h want %h", w, e); end
        if (lat !== 3) begin n_fail++; $display("FAIL cold_latency: got %0d want 3", lat); end
        if (acc_log.size() !== 2) begin
            n_fail++; $display("FAIL cold_words: got %0d accepted want 2", acc_log.size());
        end else begin
            n_vec += 2;
            if (acc_log[0] !== 32'h40) begin n_fail++; $display("FAIL cold_addr0: got %h want 00000040", acc_log[0]); end
            if (acc_log[1] !== 32'h44) begin n_fail++; $display("FAIL cold_addr1: got %h want 00000044", acc_log[1]); end
        end
    endtask

    task automatic test_block_reuse();
        int lat;
        logic [31:0] w, e;
        fetch(32'h0000_0044, lat, w);
        e = exp_q.pop_front();
        n_vec += 3;
        if (w !== e) begin n_fail++; $display("FAIL reuse_data: got %h want %h", w, e); end
        if (lat !== 0) begin n_fail++; $display("FAIL reuse_latency: got %0d want 0", lat); end
        if (ren_seen !== 1'b0) begin n_fail++; $display("FAIL reuse_iREN: got iREN activity want none"); end
    endtask

    // Set 8 already holds 0x040 (way 0). Sequence exercises fill into the
    // invalid way, LRU eviction of 0x040, LRU refresh by a hit on 0x240.
    task automatic test_lru();
        logic [31:0] addrs [8] = '{32'h240, 32'h440, 32'h240, 32'h640,
                                   32'h240, 32'h440, 32'h444, 32'h040};
        int          lats  [8] = '{3, 3, 0, 3, 0, 3, 0, 3};
        int lat;
        logic [31:0] w, e;
        stall_n = 0;
        for (int i = 0; i < 8; i++) begin
            fetch(addrs[i], lat, w);
            e = exp_q.pop_front();
            n_vec += 2;
            if (w !== e) begin n_fail++; $display("FAIL lru_data[%0d]: addr %h got %h want %h", i, addrs[i], w, e); end
            if (lat !== lats[i]) begin n_fail++; $display("FAIL lru_latency[%0d]: addr %h got %0d want %0d", i, addrs[i], lat, lats[i]); end
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [31:0] w, e;
        stall_n = 3;
        fetch(32'h0000_1088, lat, w);
        e = exp_q.pop_front();
        n_vec += 3;
        if (w !== e) begin n_fail++; $display("FAIL stall_data: got %h want %h", w, e); end
        if (lat !== WPB * (3 + 1) + 1) begin n_fail++; $display("FAIL stall_latency: got %0d want %0d", lat, WPB * 4 + 1); end
        if (acc_log.size() !== WPB) begin n_fail++; $display("FAIL stall_words: got %0d want %0d", acc_log.size(), WPB); end
        fetch(32'h0000_108C, lat, w);
        e = exp_q.pop_front();
        n_vec += 2;
        if (w !== e) begin n_fail++; $display("FAIL stall_word1_data: got %h want %h", w, e); end
        if (lat !== 0) begin n_fail++; $display("FAIL stall_word1_latency: got %0d want 0", lat); end
        stall_n = 0;
    endtask

    task automatic test_flush();
        logic [31:0] addrs [3] = '{32'h040, 32'h108C, 32'h840};
        int lat;
        logic [31:0] w, e;
        stall_n   = 0;
        stall_cnt = 0;
        fill_base = 32'h840;
        fill_idx  = 0;
        cyc(1'b1, 32'h840, 1'b0);
        n_vec++;
        if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_miss_ihit: got %b want 0", ihit); end
        cyc(1'b1, 32'h840, 1'b1);
        n_vec++;
        if (iREN !== 1'b1) begin n_fail++; $display("FAIL flush_fill_iREN: got %b want 1", iREN); end
        cyc(1'b0, 32'h0, 1'b0);
        n_vec++;
        if (iREN !== 1'b0) begin n_fail++; $display("FAIL flush_abort_iREN: got %b want 0", iREN); end
        // Everything, including lines in other sets and the partial block,
        // must now miss.
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i], lat, w);
            e = exp_q.pop_front();
            n_vec += 2;
            if (w !== e) begin n_fail++; $display("FAIL flush_refill_data[%0d]: got %h want %h", i, w, e); end
            if (lat !== 3) begin n_fail++; $display("FAIL flush_refill_latency[%0d]: got %0d want 3", i, lat); end
        end
        // flush in IDLE on a would-be hit suppresses the hit.
        cyc(1'b1, 32'h840, 1'b1);
        n_vec++;
        if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ihit: got %b want 0", ihit); end
        fetch(32'h840, lat, w);
        e = exp_q.pop_front();
        n_vec += 2;
        if (w !== e) begin n_fail++; $display("FAIL flush_idle_data: got %h want %h", w, e); end
        if (lat !== 3) begin n_fail++; $display("FAIL flush_idle_latency: got %0d want 3", lat); end
    endtask

    task automatic test_reset_mid_fill();
        int lat;
        logic [31:0] w, e;
        stall_n   = 5;
        stall_cnt = 0;
        fill_base = 32'h3000;
        fill_idx  = 0;
        cyc(1'b1, 32'h3000, 1'b0);
        cyc(1'b1, 32'h3000, 1'b0);
        n_vec++;
        if (iREN !== 1'b1) begin n_fail++; $display("FAIL rst_fill_iREN: got %b want 1", iREN); end
        nRST = 1'b0;
        #1;
        n_vec += 2;
        if (iREN !== 1'b0) begin n_fail++; $display("FAIL rst_async_iREN: got %b want 0", iREN); end
        if (iaddr !== 32'h0) begin n_fail++; $display("FAIL rst_async_iaddr: got %h want 0", iaddr); end
        imemREN = 1'b0;
        @(negedge CLK);
        nRST    = 1'b1;
        stall_n = 0;
        // 0x840 was resident before the reset; it must be gone.
        fetch(32'h840, lat, w);
        e = exp_q.pop_front();
        n_vec += 2;
        if (w !== e) begin n_fail++; $display("FAIL rst_refill_data: got %h want %h", w, e); end
        if (lat !== 3) begin n_fail++; $display("FAIL rst_refill_latency: got %0d want 3", lat); end
    endtask

    // Random fetches over 3 tags x 2 sets x 2 words with random stalls,
    // predicted by an independent 2-way LRU model.
    task automatic test_back_to_back();
        bit               m_valid [2][16];
        logic [TAG_W-1:0] m_tag   [2][16];
        bit               m_lru   [16];
        logic [31:0]      a, w, e;
        logic [TAG_W-1:0] t;
        int               s, lat, exp_lat, hw, vic, st;
        bit               hit;
        cyc(1'b0, 32'h0, 1'b1);
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 16; y++) begin
                m_valid[x][y] = 1'b0;
                m_tag[x][y]   = '0;
            end
        end
        for (int y = 0; y < 16; y++) m_lru[y] = 1'b0;
        for (int n = 0; n < 40; n++) begin
            a = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(2, 3)) << 3)
              | (32'($urandom_range(0, 1)) << 2);
            st = $urandom_range(0, 2);
            t  = a[31:7];
            s  = int'(a[6:3]);
            hit = 1'b0;
            hw  = 0;
            for (int x = 0; x < 2; x++) begin
                if (m_valid[x][s] && m_tag[x][s] == t) begin
                    hit = 1'b1;
                    hw  = x;
                end
            end
            if (hit) begin
                exp_lat  = 0;
                m_lru[s] = (hw == 0);
            end else begin
                exp_lat = WPB * (st + 1) + 1;
                vic = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : int'(m_lru[s]));
                m_valid[vic][s] = 1'b1;
                m_tag[vic][s]   = t;
                m_lru[s]        = (vic == 0);
            end
            stall_n = st;
            fetch(a, lat, w);
            e = exp_q.pop_front();
            n_vec += 2;
            if (w !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: addr %h got %h want %h", n, a, w, e); end
            if (lat !== exp_lat) begin n_fail++; $display("FAIL b2b_latency[%0d]: addr %h got %0d want %0d", n, a, lat, exp_lat); end
        end
        stall_n = 0;
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        int lat;
        logic [31:0] w, e;
        logic [31:0] addrs [5] = '{32'h1C0, 32'h1C4, 32'h1C0, 32'h1C4, 32'h1C0};
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch(addrs[i], lat, w);
            e = exp_q.pop_front();
            n_vec++;
            if (w !== e) begin n_fail++; $display("FAIL stats_data[%0d]: got %h want %h", i, w, e); end
        end
        cyc(1'b0, 32'h0, 1'b0);
        n_vec += 2;
        if (miss_count !== 32'd1) begin n_fail++; $display("FAIL stats_miss_count: got %0d want 1", miss_count); end
        if (hit_count !== 32'd5) begin n_fail++; $display("FAIL stats_hit_count: got %0d want 5", hit_count); end
        nRST = 1'b0;
        #1;
        n_vec += 2;
        if (miss_count !== 32'd0) begin n_fail++; $display("FAIL stats_rst_miss: got %0d want 0", miss_count); end
        if (hit_count !== 32'd0) begin n_fail++; $display("FAIL stats_rst_hit: got %0d want 0", hit_count); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask
`endif

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_cold_miss();
        test_block_reuse();
        test_lru();
        test_stall();
        test_flush();
        test_reset_mid_fill();
        test_back_to_back();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
